phy_tx_lanes: RTL and testbench

Multi-lane, fabric-side transmit controller that feeds a bank of `LANES` OSERDES-based output PHYs from a single `clk_div_in` domain. It buffers parallel words through a valid/ready stream with packet framing, holds the serializers in reset after power-up, and emits a link-training pattern on request. When no data is available it emits an idle word and flags underflows. Its `data_to_oserdes` slices drive each PHY's `data_from_fabric`, and `oserdes_rst` drives each PHY's serializer reset.

---
 rtl/phy_tx_pkg.sv | 21 ++
 rtl/phy_tx_lanes_if.sv | 13 +
 rtl/phy_tx_fifo.sv | 52 +++++
 rtl/phy_tx_lanes.sv | 136 +++++++++++++
 tb/tb_phy_tx_lanes.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/phy_tx_pkg.sv
// Shared types and helpers for the multi-lane OSERDES transmit controller.
package phy_tx_pkg;

  localparam int REV_MAX_W = 64;

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_TRAIN  = 2'd2,
    ST_STREAM = 2'd3
  } state_t;

  // Mirrors the low 'width' bits of v; bits above 'width' come back as zero.
  function automatic logic [REV_MAX_W-1:0] bit_reverse(input logic [REV_MAX_W-1:0] v,
                                                       input int width);
    bit_reverse = '0;
    for (int i = 0; i < width; i++)
      bit_reverse[i] = v[width-1-i];
  endfunction

endpackage

// File: rtl/phy_tx_lanes_if.sv
// Valid/ready word stream with packet framing into the transmit controller.
interface phy_tx_lanes_if #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 8
);
  logic [LANES*DATA_WIDTH-1:0] s_data;
  logic                        s_valid;
  logic                        s_last;
  logic                        s_ready;

  modport master (output s_data, output s_valid, output s_last, input  s_ready);
  modport slave  (input  s_data, input  s_valid, input  s_last, output s_ready);
endinterface

// File: rtl/phy_tx_fifo.sv
// Synchronous show-ahead FIFO: dout always presents the head word while not empty.
module phy_tx_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                       clk_div_in,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  // A full FIFO refuses the write even when a pop frees a slot on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_div_in) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: storage has no reset; emptiness is tracked by the pointers and level alone.
  always_ff @(posedge clk_div_in) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/phy_tx_lanes.sv
// Fabric-side transmit controller driving a bank of OSERDES lanes: serializer
// reset hold, link-training bursts, and buffered packet streaming.
module phy_tx_lanes #(
  parameter int                    LANES       = 4,
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    FIFO_DEPTH  = 16,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = 8'h00,
  parameter logic [DATA_WIDTH-1:0] TRAIN_WORD  = 8'hA5,
  parameter int                    RST_CYCLES  = 4,
  parameter bit                    BIT_REVERSE = 1'b0
) (
  input  logic                            clk_div_in,
  input  logic                            reset_n,
  phy_tx_lanes_if.slave                   s,
  input  logic                            train_req,
  input  logic [15:0]                     train_len,
  output logic                            train_done,
  output logic                            oserdes_rst,
  output logic [LANES*DATA_WIDTH-1:0]     data_to_oserdes,
  output logic                            underflow,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);
  import phy_tx_pkg::*;

  localparam int W      = LANES * DATA_WIDTH;
  localparam int HOLD_W = (RST_CYCLES > 2) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((RST_CYCLES > 1) ? RST_CYCLES - 1 : 0);

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [15:0]       train_cnt;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [W:0]        fifo_dout;
  logic              head_last;
  logic [W-1:0]      head_data;

  // Applies the optional per-lane bit mirror to anything headed for the serializers.
  function automatic logic [W-1:0] out_map(input logic [W-1:0] word);
    logic [REV_MAX_W-1:0] r;
    out_map = word;
    if (BIT_REVERSE) begin
      for (int k = 0; k < LANES; k++) begin
        r = bit_reverse(REV_MAX_W'(word[k*DATA_WIDTH +: DATA_WIDTH]), DATA_WIDTH);
        out_map[k*DATA_WIDTH +: DATA_WIDTH] = r[DATA_WIDTH-1:0];
      end
    end
  endfunction

  assign {head_last, head_data} = fifo_dout;
  assign s.s_ready = (state != ST_HOLD) && !fifo_full;

  phy_tx_fifo #(
    .WIDTH (W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_div_in (clk_div_in),
    .reset_n    (reset_n),
    .push       (s.s_valid && s.s_ready),
    .pop        (fifo_pop),
    .din        ({s.s_last, s.s_data}),
    .dout       (fifo_dout),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (fifo_level)
  );

  // NOTE: the default first keeps this purely combinational; a missing branch would infer a latch.
  always_comb begin
    fifo_pop = 1'b0;
    if (!fifo_empty) begin
      if (state == ST_STREAM)                   fifo_pop = 1'b1;
      else if (state == ST_IDLE && !train_req)  fifo_pop = 1'b1;
    end
  end

  // State tracks what the output register shows; each edge loads the word for the state being entered.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_div_in) begin
    if (!reset_n) begin
      state           <= ST_HOLD;
      hold_cnt        <= '0;
      train_cnt       <= '0;
      train_done      <= 1'b0;
      oserdes_rst     <= 1'b1;
      underflow       <= 1'b0;
      data_to_oserdes <= out_map({LANES{IDLE_WORD}});
    end else begin
      train_done <= 1'b0;
      case (state)
        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state       <= ST_IDLE;
            oserdes_rst <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          data_to_oserdes <= out_map({LANES{IDLE_WORD}});
          if (train_req) begin
            state           <= ST_TRAIN;
            data_to_oserdes <= out_map({LANES{TRAIN_WORD}});
            train_cnt       <= (train_len == 16'd0) ? 16'd1 : train_len;
            train_done      <= (train_len <= 16'd1);
          end else if (!fifo_empty) begin
            state           <= head_last ? ST_IDLE : ST_STREAM;
            data_to_oserdes <= out_map(head_data);
          end
        end
        ST_TRAIN: begin
          if (train_cnt == 16'd1) begin
            state           <= ST_IDLE;
            data_to_oserdes <= out_map({LANES{IDLE_WORD}});
          end else begin
            train_cnt       <= train_cnt - 1'b1;
            train_done      <= (train_cnt == 16'd2);
            data_to_oserdes <= out_map({LANES{TRAIN_WORD}});
          end
        end
        ST_STREAM: begin
          if (!fifo_empty) begin
            data_to_oserdes <= out_map(head_data);
            if (head_last) state <= ST_IDLE;
          end else begin
            data_to_oserdes <= out_map({LANES{IDLE_WORD}});
            underflow       <= 1'b1;
          end
        end
        default: state <= ST_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_phy_tx_lanes.sv
// Directed bench for phy_tx_lanes: a cycle table for the default instance plus
// hand sequences for FIFO full, bit reverse and mid-packet reset.
module tb_phy_tx_lanes;
  localparam int LANES = 4;
  localparam int DW    = 8;
  localparam int W     = LANES * DW;

  logic clk_div_in = 1'b0;
  always #5 clk_div_in = ~clk_div_in;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance 1: all defaults
  logic          reset_n, train_req, train_done, oserdes_rst, underflow;
  logic [15:0]   train_len;
  logic [W-1:0]  dout;
  logic [4:0]    level;
  phy_tx_lanes_if #(.LANES(LANES), .DATA_WIDTH(DW)) bus ();

  phy_tx_lanes dut (
    .clk_div_in      (clk_div_in),
    .reset_n         (reset_n),
    .s               (bus),
    .train_req       (train_req),
    .train_len       (train_len),
    .train_done      (train_done),
    .oserdes_rst     (oserdes_rst),
    .data_to_oserdes (dout),
    .underflow       (underflow),
    .fifo_level      (level)
  );

  // Instance 2: bit-reversed, non-palindromic idle/train words
  logic          reset2_n, train_req2, train_done2, oserdes_rst2, underflow2;
  logic [15:0]   train_len2;
  logic [W-1:0]  dout2;
  logic [4:0]    level2;
  phy_tx_lanes_if #(.LANES(LANES), .DATA_WIDTH(DW)) bus2 ();

  phy_tx_lanes #(
    .IDLE_WORD   (8'h0F),
    .TRAIN_WORD  (8'h12),
    .BIT_REVERSE (1'b1)
  ) dut_rev (
    .clk_div_in      (clk_div_in),
    .reset_n         (reset2_n),
    .s               (bus2),
    .train_req       (train_req2),
    .train_len       (train_len2),
    .train_done      (train_done2),
    .oserdes_rst     (oserdes_rst2),
    .data_to_oserdes (dout2),
    .underflow       (underflow2),
    .fifo_level      (level2)
  );

  typedef struct {
    logic        valid;
    logic        last;
    logic [31:0] data;
    logic        treq;
    logic [15:0] tlen;
    logic        rdy;
    logic        orst;
    logic [31:0] dout;
    logic        done;
    logic        uf;
    logic [4:0]  lvl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic l, input logic [31:0] d, input logic tr,
                     input logic [15:0] tl, input logic rdy, input logic orst,
                     input logic [31:0] exp_d, input logic done, input logic uf,
                     input logic [4:0] lvl);
    vec_t e;
    e.valid = v;   e.last = l;    e.data = d;     e.treq = tr; e.tlen = tl;
    e.rdy   = rdy; e.orst = orst; e.dout = exp_d; e.done = done; e.uf = uf; e.lvl = lvl;
    vecs.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_div_in);
    #1;
  endtask

  task automatic wait_rdy2(input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (bus2.s_ready === 1'b1) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  function automatic logic [31:0] fill_word(input int i);
    return 32'h0101_0101 * 32'(i + 1);
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;

    reset_n = 1'b0;  train_req = 1'b0;  train_len = '0;
    bus.s_valid = 1'b0;  bus.s_last = 1'b0;  bus.s_data = '0;
    reset2_n = 1'b0; train_req2 = 1'b0; train_len2 = '0;
    bus2.s_valid = 1'b0; bus2.s_last = 1'b0; bus2.s_data = '0;

    //    v  l  data           tr tlen   rdy orst dout           done uf lvl
    add(0, 0, 32'h0,         0, 16'd0, 0,  1,  32'h0,         0,   0, 5'd0);  // HOLD
    add(1, 0, 32'hDEADBEEF,  0, 16'd0, 0,  1,  32'h0,         0,   0, 5'd0);  // push ignored in HOLD
    add(0, 0, 32'h0,         0, 16'd0, 0,  1,  32'h0,         0,   0, 5'd0);
    add(0, 0, 32'h0,         0, 16'd0, 1,  0,  32'h0,         0,   0, 5'd0);  // leave HOLD
    add(1, 0, 32'h11111111,  0, 16'd0, 1,  0,  32'h0,         0,   0, 5'd1);
    add(1, 0, 32'h22222222,  0, 16'd0, 1,  0,  32'h11111111,  0,   0, 5'd1);
    add(1, 1, 32'h33333333,  0, 16'd0, 1,  0,  32'h22222222,  0,   0, 5'd1);
    add(0, 0, 32'h0,         0, 16'd0, 1,  0,  32'h33333333,  0,   0, 5'd0);
    add(0, 0, 32'h0,         0, 16'd0, 1,  0,  32'h0,         0,   0, 5'd0);
    add(0, 0, 32'h0,         1, 16'd5, 1,  0,  32'hA5A5A5A5,  0,   0, 5'd0);  // train 5
    add(0, 0, 32'h0,         0, 16'd0, 1,  0,  32'hA5A5A5A5,  0,   0, 5'd0);
    add(0, 0, 32'h0,         0, 16'd0, 1,  0,  32'hA5A5A5A5,  0,   0, 5'd0);
    add(0, 0, 32'h0,         0, 16'd0, 1,  0,  32'hA5A5A5A5,  0,   0, 5'd0);
    add(0, 0, 32'h0,         0, 16'd0, 1,  0,  32'hA5A5A5A5,  1,   0, 5'd0);
    add(0, 0, 32'h0,         0, 16'd0, 1,  0,  32'h0,         0,   0, 5'd0);
    add(0, 0, 32'h0,         1, 16'd0, 1,  0,  32'hA5A5A5A5,  1,   0, 5'd0);  // train 0 -> 1
    add(0, 0, 32'h0,         0, 16'd0, 1,  0,  32'h0,         0,   0, 5'd0);
    add(1, 0, 32'h44444444,  0, 16'd0, 1,  0,  32'h0,         0,   0, 5'd1);
    add(0, 0, 32'h0,         1, 16'd2, 1,  0,  32'hA5A5A5A5,  0,   0, 5'd1);  // train beats FIFO
    add(0, 0, 32'h0,         0, 16'd0, 1,  0,  32'hA5A5A5A5,  1,   0, 5'd1);
    add(0, 0, 32'h0,         0, 16'd0, 1,  0,  32'h0,         0,   0, 5'd1);
    add(0, 0, 32'h0,         0, 16'd0, 1,  0,  32'h44444444,  0,   0, 5'd0);
    add(0, 0, 32'h0,         0, 16'd0, 1,  0,  32'h0,         0,   1, 5'd0);  // underflow
    add(0, 0, 32'h0,         1, 16'd3, 1,  0,  32'h0,         0,   1, 5'd0);  // train ignored
    add(0, 0, 32'h0,         0, 16'd0, 1,  0,  32'h0,         0,   1, 5'd0);
    add(1, 1, 32'h55555555,  0, 16'd0, 1,  0,  32'h0,         0,   1, 5'd1);
    add(0, 0, 32'h0,         0, 16'd0, 1,  0,  32'h55555555,  0,   1, 5'd0);
    add(0, 0, 32'h0,         0, 16'd0, 1,  0,  32'h0,         0,   1, 5'd0);

    step(); step();
    check("rst s_ready",     32'(bus.s_ready), 32'd0);
    check("rst oserdes_rst", 32'(oserdes_rst), 32'd1);
    check("rst data",        dout,             32'h0);
    check("rst train_done",  32'(train_done),  32'd0);
    check("rst underflow",   32'(underflow),   32'd0);
    check("rst level",       32'(level),       32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.s_valid = vecs[i].valid;
      bus.s_last  = vecs[i].last;
      bus.s_data  = vecs[i].data;
      train_req   = vecs[i].treq;
      train_len   = vecs[i].tlen;
      step();
      check($sformatf("v%0d s_ready", i),     32'(bus.s_ready), 32'(vecs[i].rdy));
      check($sformatf("v%0d oserdes_rst", i), 32'(oserdes_rst), 32'(vecs[i].orst));
      check($sformatf("v%0d data", i),        dout,             vecs[i].dout);
      check($sformatf("v%0d train_done", i),  32'(train_done),  32'(vecs[i].done));
      check($sformatf("v%0d underflow", i),   32'(underflow),   32'(vecs[i].uf));
      check($sformatf("v%0d level", i),       32'(level),       32'(vecs[i].lvl));
    end
    bus.s_valid = 1'b0;

    // Fill to full while training blocks the drain
    train_req = 1'b1;
    train_len = 16'd3;
    step();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("fill%0d s_ready", i), 32'(bus.s_ready), 32'd1);
      bus.s_valid = 1'b1;
      bus.s_data  = fill_word(i);
      bus.s_last  = (i == 15);
      step();
    end
    bus.s_valid = 1'b0;
    check("full level",   32'(level),       32'd16);
    check("full s_ready", 32'(bus.s_ready), 32'd0);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hBADBAD00;
    bus.s_last  = 1'b1;
    step();
    bus.s_valid = 1'b0;
    check("full reject level", 32'(level), 32'd16);
    train_req = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      step();
      if (dout === fill_word(0)) found = 1'b1;
    end
    check("drain start", 32'(found), 32'd1);
    for (int i = 1; i < 16; i++) begin
      step();
      check($sformatf("drain%0d data", i), dout, fill_word(i));
    end
    step();
    check("drain end data",  dout,        32'h0);
    check("drain end level", 32'(level),  32'd0);

    // Bit-reversed instance
    check("rev rst data",    dout2,              32'hF0F0F0F0);
    check("rev rst orst",    32'(oserdes_rst2),  32'd1);
    check("rev rst s_ready", 32'(bus2.s_ready),  32'd0);
    reset2_n = 1'b1;
    wait_rdy2("rev hold exit");
    check("rev orst low", 32'(oserdes_rst2), 32'd0);
    train_req2 = 1'b1;
    train_len2 = 16'd3;
    step();
    check("rev train data", dout2,             32'h48484848);
    check("rev train done", 32'(train_done2),  32'd0);
    train_req2 = 1'b0;
    step();
    reset2_n = 1'b0;
    step();
    check("rev abort done", 32'(train_done2),  32'd0);
    check("rev abort orst", 32'(oserdes_rst2), 32'd1);
    check("rev abort data", dout2,             32'hF0F0F0F0);
    step();
    check("rev abort done2", 32'(train_done2), 32'd0);
    reset2_n = 1'b1;
    wait_rdy2("rev hold exit 2");

    bus2.s_valid = 1'b1; bus2.s_last = 1'b0; bus2.s_data = 32'h01020304;
    step();
    check("rev push0 level", 32'(level2), 32'd1);
    check("rev push0 data",  dout2,       32'hF0F0F0F0);
    bus2.s_data = 32'h0A0B0C0D;
    step();
    check("rev word0", dout2, 32'h8040C020);
    bus2.s_data = 32'h11223344; bus2.s_last = 1'b1;
    step();
    check("rev word1",       dout2,       32'h50D030B0);
    check("rev word1 level", 32'(level2), 32'd1);
    bus2.s_valid = 1'b0;
    reset2_n = 1'b0;
    step();
    check("rev midpkt level",     32'(level2),       32'd0);
    check("rev midpkt orst",      32'(oserdes_rst2), 32'd1);
    check("rev midpkt s_ready",   32'(bus2.s_ready), 32'd0);
    check("rev midpkt underflow", 32'(underflow2),   32'd0);
    check("rev midpkt data",      dout2,             32'hF0F0F0F0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
